stack_arbiter: RTL and testbench

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_arb_pkg.sv | 39 +++
 rtl/rr_arbiter2.sv | 30 +++
 rtl/stack_arbiter.sv | 155 +++++++++++++++
 tb/tb_stack_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_arb_pkg.sv
// Shared encodings for the two-requester stack arbiter.
// Holds op codes, response status codes, stack command codes and FSM states.
// STACK_ARB_PEEK_EN adds the RESTORE state used to put a peeked word back.
package stack_arb_pkg;

   // Requester operation codes
   typedef enum logic [1:0] {
      OP_UNDEF = 2'b00,
      OP_PUSH  = 2'b01,
      OP_POP   = 2'b10,
      OP_PEEK  = 2'b11
   } op_e;

   // Response status returned alongside ack
   typedef enum logic [1:0] {
      ERR_OK        = 2'b00,
      ERR_OVERFLOW  = 2'b01,
      ERR_UNDERFLOW = 2'b10,
      ERR_UNDEFINED = 2'b11
   } err_e;

   // Command presented to the stack memory
   typedef enum logic [1:0] {
      MEM_NOP  = 2'b00,
      MEM_PUSH = 2'b01,
      MEM_POP  = 2'b10
   } mem_e;

   // Arbiter FSM; RESTORE only exists when peek support is built in
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC    = 2'd1,
`ifdef STACK_ARB_PEEK_EN
      ST_RESTORE = 2'd2,
`endif
      ST_RESP    = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick with a last-granted pointer.
// Latency: pick is combinational; pointer updates on the clock edge of a grant.
// Backpressure: i_en gates the pointer update; the pick is only a suggestion until then.
// Ports: clk/rst (async active-high), i_req[1:0] requests, i_en grant strobe,
//        o_vld any request present, o_idx index of the chosen requester.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_en,
   output logic       o_vld,
   output logic       o_idx
);

   // Reset to 1 so requester 0 wins the first contested grant
   logic r_last;

   assign o_vld = |i_req;
   // Contested: the one not granted last. Otherwise the lone requester.
   assign o_idx = (i_req[0] && i_req[1]) ? ~r_last : i_req[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (i_en && o_vld) begin
         r_last <= o_idx;
      end
   end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto one stack memory (push / pop / optional peek).
// Latency: req seen in IDLE at cycle n -> ack at n+2 (n+3 for a successful peek).
// Backpressure: one operation in flight; other requests wait in place until IDLE.
// Ports: clk, rst (async active-high); req/op/wdata per requester in, ack per
//        requester out with shared rdata/err; mem_cntrl/mem_wdata drive the stack,
//        mem_rdata/mem_full/mem_empty come back from it.
// Build option: define STACK_ARB_PEEK_EN to enable op 11 as PEEK (pop then re-push).
module stack_arbiter
   import stack_arb_pkg::*;
#(
   parameter int DW = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [1:0]    op0,
   input  logic [1:0]    op1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic [1:0]    err,
   output logic [1:0]    mem_cntrl,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_full,
   input  logic          mem_empty
);

   state_e        r_state;
   state_e        w_state_nxt;
   logic          r_gnt;
   logic [1:0]    r_op;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata;
   logic [1:0]    r_err;

   logic          w_gnt_vld;
   logic          w_gnt_idx;
   logic          w_idle;
   logic [1:0]    w_mem_cntrl;
   logic [DW-1:0] w_mem_wdata;
   logic [DW-1:0] w_rdata_nxt;
   logic [1:0]    w_err_nxt;

   assign w_idle = (r_state == ST_IDLE);

   rr_arbiter2 u_rr (
      .clk   (clk),
      .rst   (rst),
      .i_req ({req1, req0}),
      .i_en  (w_idle),
      .o_vld (w_gnt_vld),
      .o_idx (w_gnt_idx)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_mem_cntrl = MEM_NOP;
      w_mem_wdata = '0;
      w_rdata_nxt = '0;
      w_err_nxt   = ERR_OK;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_vld) begin
               w_state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            w_state_nxt = ST_RESP;
            case (r_op)
               OP_PUSH: begin
                  if (!mem_full) begin
                     w_mem_cntrl = MEM_PUSH;
                     w_mem_wdata = r_wdata;
                  end else begin
                     w_err_nxt = ERR_OVERFLOW;
                  end
               end
               OP_POP: begin
                  if (!mem_empty) begin
                     w_mem_cntrl = MEM_POP;
                     w_rdata_nxt = mem_rdata;
                  end else begin
                     w_err_nxt = ERR_UNDERFLOW;
                  end
               end
`ifdef STACK_ARB_PEEK_EN
               OP_PEEK: begin
                  // Peek is a pop whose word is pushed back in RESTORE
                  if (!mem_empty) begin
                     w_mem_cntrl = MEM_POP;
                     w_rdata_nxt = mem_rdata;
                     w_state_nxt = ST_RESTORE;
                  end else begin
                     w_err_nxt = ERR_UNDERFLOW;
                  end
               end
`endif
               default: begin
                  w_err_nxt = ERR_UNDEFINED;
               end
            endcase
         end
`ifdef STACK_ARB_PEEK_EN
         ST_RESTORE: begin
            // Stack had at least one free slot after the pop, so no full check
            w_mem_cntrl = MEM_PUSH;
            w_mem_wdata = r_rdata;
            w_state_nxt = ST_RESP;
         end
`endif
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_gnt   <= 1'b0;
         r_op    <= 2'b00;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= ERR_OK;
      end else begin
         r_state <= w_state_nxt;
         // Op and data are frozen at grant; later requester changes are ignored
         if (w_idle && w_gnt_vld) begin
            r_gnt   <= w_gnt_idx;
            r_op    <= w_gnt_idx ? op1 : op0;
            r_wdata <= w_gnt_idx ? wdata1 : wdata0;
         end
         if (r_state == ST_EXEC) begin
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
         end
      end
   end

   // Outputs decode from the state register so reset clears them immediately
   assign ack0      = (r_state == ST_RESP) && !r_gnt;
   assign ack1      = (r_state == ST_RESP) &&  r_gnt;
   assign rdata     = (r_state == ST_RESP) ? r_rdata : '0;
   assign err       = (r_state == ST_RESP) ? r_err : ERR_OK;
   assign mem_cntrl = w_mem_cntrl;
   assign mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

   localparam int DW = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1;
   logic [1:0]    op0, op1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1;
   logic [DW-1:0] rdata;
   logic [1:0]    err;
   logic [1:0]    mem_cntrl;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_full, mem_empty;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stack_arbiter #(.DW(DW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
      .mem_cntrl(mem_cntrl), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_full(mem_full), .mem_empty(mem_empty)
   );

   // Depth-8 stack model with command counters
   logic [DW-1:0] stk [0:7];
   int            cnt = 0;
   int            n_push = 0;
   int            n_pop = 0;
   logic [DW-1:0] last_push = '0;
   logic          tb_clr = 1'b0;

   always @(posedge clk) begin
      if (mem_cntrl == 2'b01) begin
         n_push <= n_push + 1;
         last_push <= mem_wdata;
      end
      if (mem_cntrl == 2'b10) n_pop <= n_pop + 1;
      if (tb_clr) cnt <= 0;
      else if (mem_cntrl == 2'b01 && cnt < 8) begin
         stk[cnt] <= mem_wdata;
         cnt <= cnt + 1;
      end else if (mem_cntrl == 2'b10 && cnt > 0) begin
         cnt <= cnt - 1;
      end
   end

   assign mem_rdata = (cnt > 0) ? stk[cnt-1] : '0;
   assign mem_full  = (cnt == 8);
   assign mem_empty = (cnt == 0);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clr_stack();
      @(negedge clk); tb_clr = 1'b1;
      @(negedge clk); tb_clr = 1'b0;
   endtask

   // Drives one request, waits (bounded) for its ack, drops req after ack
   task automatic do_op(input int who, input logic [1:0] o, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output logic [1:0] e,
                        output int lat, output bit got);
      @(negedge clk);
      if (who == 0) begin req0 = 1'b1; op0 = o; wdata0 = d; end
      else          begin req1 = 1'b1; op1 = o; wdata1 = d; end
      got = 1'b0; lat = 0; rd = '0; e = 2'b00;
      for (int c = 1; c <= 10 && !got; c++) begin
         @(negedge clk);
         if ((who == 0) ? ack0 : ack1) begin
            got = 1'b1; lat = c; rd = rdata; e = err;
         end
      end
      if (who == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0 = 0; req1 = 0; op0 = 0; op1 = 0; wdata0 = 0; wdata1 = 0;
      repeat (2) @(negedge clk);
      n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("FAIL rst_ack0: got %0h want 0", ack0); end
      n_cmp++; if (ack1 !== 1'b0) begin n_bad++; $display("FAIL rst_ack1: got %0h want 0", ack1); end
      n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL rst_rdata: got %0h want 0", rdata); end
      n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %0h want 0", err); end
      n_cmp++; if (mem_cntrl !== 2'b00) begin n_bad++; $display("FAIL rst_mem_cntrl: got %0h want 0", mem_cntrl); end
      n_cmp++; if (mem_wdata !== '0) begin n_bad++; $display("FAIL rst_mem_wdata: got %0h want 0", mem_wdata); end
      rst = 1'b0;
   endtask

   task automatic test_push_latency();
      @(negedge clk);
      req0 = 1'b1; op0 = 2'b01; wdata0 = 20'h00005;
      @(negedge clk);
      n_cmp++; if (mem_cntrl !== 2'b01) begin n_bad++; $display("FAIL push_cmd_c1: got %0h want 1", mem_cntrl); end
      n_cmp++; if (mem_wdata !== 20'h00005) begin n_bad++; $display("FAIL push_wdata_c1: got %0h want 5", mem_wdata); end
      n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("FAIL push_early_ack: got %0h want 0", ack0); end
      @(negedge clk);
      n_cmp++; if (ack0 !== 1'b1) begin n_bad++; $display("FAIL push_ack0_c2: got %0h want 1", ack0); end
      n_cmp++; if (ack1 !== 1'b0) begin n_bad++; $display("FAIL push_ack1_c2: got %0h want 0", ack1); end
      n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL push_err: got %0h want 0", err); end
      n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL push_rdata: got %0h want 0", rdata); end
      n_cmp++; if (mem_cntrl !== 2'b00) begin n_bad++; $display("FAIL push_cmd_resp: got %0h want 0", mem_cntrl); end
      req0 = 1'b0;
      @(negedge clk);
      n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("FAIL push_ack_width: got %0h want 0", ack0); end
      n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL push_depth: got %0d want 1", cnt); end
   endtask

   task automatic test_pop_contention();
      logic [DW-1:0] rd; logic [1:0] e; int lat; bit got;
      int who_q[2]; logic [DW-1:0] rd_q[2]; logic [1:0] e_q[2];
      int nack; int overlap;
      clr_stack();
      // Push from requester 1 so requester 0 holds priority for the contest
      do_op(1, 2'b01, 20'h00005, rd, e, lat, got);
      n_cmp++; if (!got || e !== 2'b00) begin n_bad++; $display("FAIL cont_preload: got ack %0d err %0h want 1/0", got, e); end
      @(negedge clk);
      req0 = 1'b1; op0 = 2'b10; req1 = 1'b1; op1 = 2'b10;
      nack = 0; overlap = 0;
      for (int c = 0; c < 20 && nack < 2; c++) begin
         @(negedge clk);
         if (ack0 && ack1) overlap++;
         if (ack0) begin who_q[nack] = 0; rd_q[nack] = rdata; e_q[nack] = err; nack++; req0 = 1'b0; end
         else if (ack1) begin who_q[nack] = 1; rd_q[nack] = rdata; e_q[nack] = err; nack++; req1 = 1'b0; end
      end
      req0 = 1'b0; req1 = 1'b0;
      n_cmp++; if (nack !== 2) begin n_bad++; $display("FAIL cont_nack: got %0d want 2", nack); end
      n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL cont_overlap: got %0d want 0", overlap); end
      if (nack == 2) begin
         n_cmp++; if (who_q[0] !== 0) begin n_bad++; $display("FAIL cont_first: got %0d want 0", who_q[0]); end
         n_cmp++; if (rd_q[0] !== 20'h00005 || e_q[0] !== 2'b00) begin n_bad++; $display("FAIL cont_pop0: got %0h/%0h want 5/0", rd_q[0], e_q[0]); end
         n_cmp++; if (who_q[1] !== 1) begin n_bad++; $display("FAIL cont_second: got %0d want 1", who_q[1]); end
         n_cmp++; if (rd_q[1] !== '0 || e_q[1] !== 2'b10) begin n_bad++; $display("FAIL cont_pop1: got %0h/%0h want 0/2", rd_q[1], e_q[1]); end
      end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] rd; logic [1:0] e; int lat; bit got; int np;
      clr_stack();
      for (int i = 0; i < 8; i++) begin
         do_op(0, 2'b01, DW'(i + 1), rd, e, lat, got);
         n_cmp++; if (!got || e !== 2'b00) begin n_bad++; $display("FAIL ovf_fill%0d: got ack %0d err %0h want 1/0", i, got, e); end
      end
      n_cmp++; if (cnt !== 8) begin n_bad++; $display("FAIL ovf_depth: got %0d want 8", cnt); end
      np = n_push;
      do_op(0, 2'b01, 20'h00009, rd, e, lat, got);
      n_cmp++; if (!got || e !== 2'b01) begin n_bad++; $display("FAIL ovf_err: got ack %0d err %0h want 1/1", got, e); end
      n_cmp++; if (n_push !== np) begin n_bad++; $display("FAIL ovf_no_push: got %0d pushes want 0", n_push - np); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ovf_latency: got %0d want 2", lat); end
      n_cmp++; if (rd !== '0) begin n_bad++; $display("FAIL ovf_rdata: got %0h want 0", rd); end
   endtask

`ifdef STACK_ARB_PEEK_EN
   task automatic test_peek();
      logic [DW-1:0] rd; logic [1:0] e; int lat; bit got; int np, npp;
      clr_stack();
      do_op(0, 2'b01, 20'h00003, rd, e, lat, got);
      do_op(0, 2'b01, 20'h00007, rd, e, lat, got);
      np = n_push; npp = n_pop;
      do_op(0, 2'b11, 20'h00000, rd, e, lat, got);
      n_cmp++; if (!got || rd !== 20'h00007 || e !== 2'b00) begin n_bad++; $display("FAIL peek_resp: got ack %0d rdata %0h err %0h want 1/7/0", got, rd, e); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL peek_latency: got %0d want 3", lat); end
      n_cmp++; if (n_pop - npp !== 1 || n_push - np !== 1) begin n_bad++; $display("FAIL peek_mem_ops: got pop %0d push %0d want 1/1", n_pop - npp, n_push - np); end
      n_cmp++; if (last_push !== 20'h00007) begin n_bad++; $display("FAIL peek_restore: got %0h want 7", last_push); end
      n_cmp++; if (cnt !== 2) begin n_bad++; $display("FAIL peek_depth: got %0d want 2", cnt); end
      do_op(0, 2'b10, 20'h00000, rd, e, lat, got);
      n_cmp++; if (!got || rd !== 20'h00007 || e !== 2'b00) begin n_bad++; $display("FAIL peek_then_pop: got rdata %0h err %0h want 7/0", rd, e); end
   endtask
`else
   task automatic test_peek();
      logic [DW-1:0] rd; logic [1:0] e; int lat; bit got; int np, npp;
      clr_stack();
      do_op(0, 2'b01, 20'h00003, rd, e, lat, got);
      np = n_push; npp = n_pop;
      do_op(0, 2'b11, 20'h00000, rd, e, lat, got);
      n_cmp++; if (!got || rd !== '0 || e !== 2'b11) begin n_bad++; $display("FAIL op11_resp: got ack %0d rdata %0h err %0h want 1/0/3", got, rd, e); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL op11_latency: got %0d want 2", lat); end
      n_cmp++; if (n_pop !== npp || n_push !== np) begin n_bad++; $display("FAIL op11_mem_ops: got pop %0d push %0d want 0/0", n_pop - npp, n_push - np); end
      n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL op11_depth: got %0d want 1", cnt); end
   endtask
`endif

   task automatic test_reset_mid();
      int nack;
      // Grant requester 0 so only a reset can restore its priority
      @(negedge clk);
      req0 = 1'b1; op0 = 2'b01; wdata0 = 20'h000AB;
      @(negedge clk);
      n_cmp++; if (mem_cntrl !== 2'b01) begin n_bad++; $display("FAIL rmid_exec: got %0h want 1", mem_cntrl); end
      #1; rst = 1'b1; req0 = 1'b0;
      #1;
      n_cmp++; if (mem_cntrl !== 2'b00 || mem_wdata !== '0) begin n_bad++; $display("FAIL rmid_mem: got %0h/%0h want 0/0", mem_cntrl, mem_wdata); end
      n_cmp++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || rdata !== '0 || err !== 2'b00) begin n_bad++; $display("FAIL rmid_outputs: got ack %0b%0b rdata %0h err %0h want 00/0/0", ack1, ack0, rdata, err); end
      @(negedge clk); rst = 1'b0;
      nack = 0;
      repeat (6) begin @(negedge clk); if (ack0 || ack1) nack++; end
      n_cmp++; if (nack !== 0) begin n_bad++; $display("FAIL rmid_no_ack: got %0d acks want 0", nack); end
   endtask

   task automatic test_alternate();
      int who_q[4]; logic [1:0] e_q[4]; int nack; int overlap;
      logic [1:0] uop;
`ifdef STACK_ARB_PEEK_EN
      uop = 2'b00;
`else
      uop = 2'b11;
`endif
      @(negedge clk);
      req0 = 1'b1; op0 = uop; req1 = 1'b1; op1 = uop;
      nack = 0; overlap = 0;
      for (int c = 0; c < 40 && nack < 4; c++) begin
         @(negedge clk);
         if (ack0 && ack1) overlap++;
         if (ack0 || ack1) begin who_q[nack] = ack1 ? 1 : 0; e_q[nack] = err; nack++; end
      end
      req0 = 1'b0; req1 = 1'b0;
      n_cmp++; if (nack !== 4) begin n_bad++; $display("FAIL alt_nack: got %0d want 4", nack); end
      n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL alt_overlap: got %0d want 0", overlap); end
      for (int i = 0; i < nack; i++) begin
         n_cmp++; if (who_q[i] !== (i % 2)) begin n_bad++; $display("FAIL alt_grant%0d: got %0d want %0d", i, who_q[i], i % 2); end
         n_cmp++; if (e_q[i] !== 2'b11) begin n_bad++; $display("FAIL alt_err%0d: got %0h want 3", i, e_q[i]); end
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_push_latency();
      test_pop_contention();
      test_overflow();
      test_peek();
      test_reset_mid();
      test_alternate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
